// File: rtl/io_pkg.sv
// Shared encodings and helpers for the accumulator processor's I/O handshake block.
package io_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned IO_IN_BIT  = 0;
    localparam int unsigned IO_OUT_BIT = 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        DONE         = 2'd3
    } io_state_t;

    typedef enum logic {
        KIND_BRK = 1'b0,
        KIND_IN  = 1'b1
    } io_kind_t;

    // Two's-complement word to display magnitude; 0x80000000 maps to itself.
    function automatic logic [WORD_W-1:0] sign_mag(input logic [WORD_W-1:0] value);
        return value[WORD_W-1] ? ~(value - WORD_W'(1)) : value;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Push-button synchronizer and debouncer producing one-cycle rise/fall pulses.
module io_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic btn_rise,
    output logic btn_fall
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   btn_sync;
    logic                   btn_db;
    logic                   accept;

    assign btn_sync = sync[SYNC_STAGES-1];

    // Pulses fire in the cycle the new level is accepted, so a consumer
    // clocking on the same edge sees the change together with btn_db.
    assign accept   = (btn_sync != btn_db) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign btn_rise = accept && btn_sync;
    assign btn_fall = accept && !btn_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], button};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (btn_sync == btn_db) begin
            cnt <= '0;
        end else if (accept) begin
            cnt    <= '0;
            btn_db <= btn_sync;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/io_handshake_ctrl.sv
// Stalls the core on IN/BRK until a debounced button press and release,
// captures the switch word, and drives the sign-magnitude display for OUT.
module io_handshake_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        IOSignal,
    input  logic              BRKSig,
    input  logic              button,
    input  logic [WORD_W-1:0] Input,
    input  logic [WORD_W-1:0] OutputRegister,
    output logic              stall,
    output logic [WORD_W-1:0] InputRegister,
    output logic              input_valid,
    output logic [WORD_W-1:0] Output,
    output logic              Negative,
    output logic              waiting
);

    io_state_t state, state_nxt;
    io_kind_t  kind, kind_nxt;
    logic      capture;
    logic      btn_rise;
    logic      btn_fall;
    logic      req_in;

    assign req_in = IOSignal[IO_IN_BIT];

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_debounce (
        .clock   (clock),
        .reset   (reset),
        .button  (button),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    always_comb begin
        state_nxt   = state;
        kind_nxt    = kind;
        capture     = 1'b0;
        stall       = 1'b0;
        input_valid = 1'b0;
        waiting     = 1'b0;
        unique case (state)
            IDLE: begin
                // Stall in the request's first cycle so the PC never moves past it.
                if (req_in || BRKSig) begin
                    stall     = 1'b1;
                    state_nxt = WAIT_PRESS;
                    kind_nxt  = req_in ? KIND_IN : KIND_BRK;
                end
            end
            WAIT_PRESS: begin
                stall   = 1'b1;
                waiting = 1'b1;
                if (btn_rise) begin
                    capture   = (kind == KIND_IN);
                    state_nxt = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                stall   = 1'b1;
                waiting = 1'b1;
                if (btn_fall) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                input_valid = (kind == KIND_IN);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            kind          <= KIND_BRK;
            InputRegister <= '0;
            Output        <= '0;
            Negative      <= 1'b0;
        end else begin
            state <= state_nxt;
            kind  <= kind_nxt;
            if (capture) begin
                InputRegister <= Input;
            end
            if (IOSignal[IO_OUT_BIT] && !stall) begin
                Output   <= sign_mag(OutputRegister);
                Negative <= OutputRegister[WORD_W-1];
            end
        end
    end

endmodule
